// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Shares one single-ported RAM between the instruction cache and the data
//   cache. One requester is granted at a time and keeps the grant until the
//   RAM reports ready (or the requester withdraws). Data requests win by
//   default; once MAX_DSTREAK data grants have been issued back-to-back while
//   an instruction request was waiting, the instruction side gets the next
//   slot. Every grant returns to IDLE for one cycle before the next
//   arbitration.
//
// Ports
//   CLK, RST          clock, synchronous active-high reset
//   iREN, iaddr       instruction read request and address
//   iload, iwait      instruction read data (follows ram_load) and stall
//   dREN, dWEN        data read / write request (write wins if both set)
//   daddr, dstore     data address and write value
//   dload, dwait      data read value (follows ram_load) and stall
//   ram_ren, ram_wen  RAM read / write strobes
//   ram_addr          RAM address
//   ram_store         RAM write data
//   ram_load          RAM read data
//   ram_ready         RAM access completes this cycle
//   gnt_i, gnt_d      instruction / data grant currently held
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MAX_DSTREAK = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic [DATA_W-1:0] iload,
    output logic              iwait,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic [DATA_W-1:0] dload,
    output logic              dwait,
    output logic              ram_ren,
    output logic              ram_wen,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_store,
    input  logic [DATA_W-1:0] ram_load,
    input  logic              ram_ready,
    output logic              gnt_i,
    output logic              gnt_d
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] IGNT = 2'd1;
    localparam logic [1:0] DGNT = 2'd2;

    // Streak counter is 4 bits wide, enough for the full 1..15 limit range.
    localparam logic [3:0] MAX_S = 4'(MAX_DSTREAK);

    logic [1:0] state_r;
    logic [1:0] state_nxt_s;
    logic [3:0] dstreak_r;
    logic [3:0] dstreak_nxt_s;
    logic       d_req_s;
    logic       i_done_s;
    logic       d_done_s;

    assign d_req_s  = dREN | dWEN;
    assign i_done_s = (state_r == IGNT) & ram_ready;
    assign d_done_s = (state_r == DGNT) & ram_ready;

    // Next-state and data-streak computation.
    always_comb begin
        state_nxt_s   = state_r;
        dstreak_nxt_s = dstreak_r;
        case (state_r)
            IDLE: begin
                // Data wins unless the instruction side has waited through
                // a full streak of data grants.
                if (d_req_s && (!iREN || (dstreak_r != MAX_S))) begin
                    state_nxt_s = DGNT;
                    if (iREN) begin
                        if (dstreak_r < MAX_S) begin
                            dstreak_nxt_s = dstreak_r + 4'd1;
                        end else begin
                            dstreak_nxt_s = MAX_S;
                        end
                    end else begin
                        dstreak_nxt_s = 4'd0;
                    end
                end else if (iREN) begin
                    state_nxt_s   = IGNT;
                    dstreak_nxt_s = 4'd0;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            IGNT: begin
                // Completion or withdrawal both fall back to IDLE; the
                // streak is untouched either way.
                if (!iREN || ram_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = IGNT;
                end
            end
            DGNT: begin
                if (!d_req_s || ram_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DGNT;
                end
            end
            default: begin
                state_nxt_s   = IDLE;
                dstreak_nxt_s = 4'd0;
            end
        endcase
    end

    // State and streak registers; reset abandons any in-flight access.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r   <= IDLE;
            dstreak_r <= 4'd0;
        end else begin
            state_r   <= state_nxt_s;
            dstreak_r <= dstreak_nxt_s;
        end
    end

    // RAM-side strobes and address/data mux driven by the current grant.
    always_comb begin
        ram_ren   = 1'b0;
        ram_wen   = 1'b0;
        ram_addr  = {ADDR_W{1'b0}};
        ram_store = {DATA_W{1'b0}};
        case (state_r)
            IGNT: begin
                ram_ren  = 1'b1;
                ram_addr = iaddr;
            end
            DGNT: begin
                // A write takes precedence when both data strobes are set.
                if (dWEN) begin
                    ram_wen   = 1'b1;
                    ram_addr  = daddr;
                    ram_store = dstore;
                end else if (dREN) begin
                    ram_ren  = 1'b1;
                    ram_addr = daddr;
                end else begin
                    ram_ren = 1'b0;
                end
            end
            IDLE: begin
                ram_ren = 1'b0;
            end
            default: begin
                ram_ren = 1'b0;
            end
        endcase
    end

    // Stalls release in the same cycle the RAM completes the granted access.
    assign iwait = iREN & ~i_done_s;
    assign dwait = d_req_s & ~d_done_s;

    // Read data is passed straight through; callers qualify it with wait.
    assign iload = ram_load;
    assign dload = ram_load;

    assign gnt_i = (state_r == IGNT);
    assign gnt_d = (state_r == DGNT);

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//   Self-checking bench for mem_arbiter. Directed cycle-level checks plus a
//   scoreboard: every access the bench expects the arbiter to perform is
//   queued when the request is driven and compared against the RAM-side bus
//   and the returned load data when the DUT completes a grant.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    logic        CLK;
    logic        RST;
    logic        iREN;
    logic [31:0] iaddr;
    logic [31:0] iload;
    logic        iwait;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic [31:0] dload;
    logic        dwait;
    logic        ram_ren;
    logic        ram_wen;
    logic [31:0] ram_addr;
    logic [31:0] ram_store;
    logic [31:0] ram_load;
    logic        ram_ready;
    logic        gnt_i;
    logic        gnt_d;

    mem_arbiter #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .MAX_DSTREAK(4)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iload    (iload),
        .iwait    (iwait),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .dload    (dload),
        .dwait    (dwait),
        .ram_ren  (ram_ren),
        .ram_wen  (ram_wen),
        .ram_addr (ram_addr),
        .ram_store(ram_store),
        .ram_load (ram_load),
        .ram_ready(ram_ready),
        .gnt_i    (gnt_i),
        .gnt_d    (gnt_d)
    );

    typedef struct {
        logic        is_d;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] store;
        logic [31:0] load;
    } exp_t;

    exp_t        sb_q[$];
    int          n_vec;
    int          n_err;
    logic        prev_cmpl;
    logic [31:0] rnd_ld;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Single comparison point: counts and reports.
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push(input logic is_d, input logic wr, input logic [31:0] addr,
                        input logic [31:0] store, input logic [31:0] load);
        exp_t e;
        e.is_d  = is_d;
        e.wr    = wr;
        e.addr  = addr;
        e.store = store;
        e.load  = load;
        sb_q.push_back(e);
    endtask

    // Advance to just after the next rising edge, where inputs are driven.
    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic sb_compare;
        exp_t e;
        if (sb_q.size() == 0) begin
            chk("sb_underflow", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            chk("sb_kind_d", {31'd0, gnt_d}, {31'd0, e.is_d});
            chk("sb_wen", {31'd0, ram_wen}, {31'd0, e.wr});
            chk("sb_ren", {31'd0, ram_ren}, {31'd0, ~e.wr});
            chk("sb_addr", ram_addr, e.addr);
            chk("sb_store", ram_store, e.store);
            if (gnt_d) begin
                chk("sb_dload", dload, e.load);
                chk("sb_dwait", {31'd0, dwait}, 32'd0);
            end else begin
                chk("sb_iload", iload, e.load);
                chk("sb_iwait", {31'd0, iwait}, 32'd0);
            end
        end
    endtask

    // Completion monitor: pops the scoreboard and enforces the IDLE gap.
    always @(negedge CLK) begin
        if (prev_cmpl) begin
            chk("idle_gap", {31'd0, gnt_i | gnt_d}, 32'd0);
        end
        if (!RST && (gnt_i || gnt_d) && ram_ready) begin
            sb_compare();
            prev_cmpl <= 1'b1;
        end else begin
            prev_cmpl <= 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec     = 0;
        n_err     = 0;
        prev_cmpl = 1'b0;
        RST       = 1'b1;
        iREN      = 1'b1;
        iaddr     = 32'h0000_0000;
        dREN      = 1'b0;
        dWEN      = 1'b1;
        daddr     = 32'h0000_0123;
        dstore    = 32'h0000_0456;
        ram_load  = 32'h0000_0000;
        ram_ready = 1'b0;

        // Reset state, with requests present to show waits mirror them.
        tick;
        tick;
        @(negedge CLK);
        chk("rst_gnt_i", {31'd0, gnt_i}, 32'd0);
        chk("rst_gnt_d", {31'd0, gnt_d}, 32'd0);
        chk("rst_ram_ren", {31'd0, ram_ren}, 32'd0);
        chk("rst_ram_wen", {31'd0, ram_wen}, 32'd0);
        chk("rst_ram_addr", ram_addr, 32'd0);
        chk("rst_ram_store", ram_store, 32'd0);
        chk("rst_iwait", {31'd0, iwait}, 32'd1);
        chk("rst_dwait", {31'd0, dwait}, 32'd1);
        tick;
        RST  = 1'b0;
        iREN = 1'b0;
        dWEN = 1'b0;

        // Test 1: isolated instruction read, ready at cycle 3.
        tick;
        iREN  = 1'b1;
        iaddr = 32'h0000_0100;
        push(1'b0, 1'b0, 32'h0000_0100, 32'd0, 32'hDEAD_BEEF);
        @(negedge CLK);
        chk("t1_iwait_c0", {31'd0, iwait}, 32'd1);
        chk("t1_gnt_c0", {31'd0, gnt_i}, 32'd0);
        tick;
        @(negedge CLK);
        chk("t1_gnt_c1", {31'd0, gnt_i}, 32'd1);
        chk("t1_ren_c1", {31'd0, ram_ren}, 32'd1);
        chk("t1_addr_c1", ram_addr, 32'h0000_0100);
        chk("t1_iwait_c1", {31'd0, iwait}, 32'd1);
        tick;
        @(negedge CLK);
        chk("t1_iwait_c2", {31'd0, iwait}, 32'd1);
        chk("t1_gnt_c2", {31'd0, gnt_i}, 32'd1);
        tick;
        ram_ready = 1'b1;
        ram_load  = 32'hDEAD_BEEF;
        @(negedge CLK);
        chk("t1_iwait_c3", {31'd0, iwait}, 32'd0);
        chk("t1_iload_c3", iload, 32'hDEAD_BEEF);
        tick;
        ram_ready = 1'b0;
        iREN      = 1'b0;
        @(negedge CLK);
        chk("t1_idle_c4", {30'd0, gnt_i, gnt_d}, 32'd0);

        // Test 2: simultaneous write and read; data wins first.
        tick;
        iREN     = 1'b1;
        iaddr    = 32'h0000_0300;
        dWEN     = 1'b1;
        daddr    = 32'h0000_0200;
        dstore   = 32'h0000_0055;
        ram_load = 32'h0000_0000;
        push(1'b1, 1'b1, 32'h0000_0200, 32'h0000_0055, 32'h0000_0000);
        push(1'b0, 1'b0, 32'h0000_0300, 32'd0, 32'h1234_5678);
        @(negedge CLK);
        chk("t2_dwait_c0", {31'd0, dwait}, 32'd1);
        tick;
        @(negedge CLK);
        chk("t2_gnt_d", {31'd0, gnt_d}, 32'd1);
        chk("t2_wen", {31'd0, ram_wen}, 32'd1);
        chk("t2_ren", {31'd0, ram_ren}, 32'd0);
        chk("t2_addr", ram_addr, 32'h0000_0200);
        chk("t2_store", ram_store, 32'h0000_0055);
        tick;
        ram_ready = 1'b1;
        tick;
        ram_ready = 1'b0;
        dWEN      = 1'b0;
        @(negedge CLK);
        chk("t2_iwait_idle", {31'd0, iwait}, 32'd1);
        tick;
        @(negedge CLK);
        chk("t2_gnt_i", {31'd0, gnt_i}, 32'd1);
        chk("t2_iaddr", ram_addr, 32'h0000_0300);
        tick;
        ram_ready = 1'b1;
        ram_load  = 32'h1234_5678;
        tick;
        ram_ready = 1'b0;
        iREN      = 1'b0;

        // Test 3: starvation limit with both sides always requesting.
        tick;
        iREN      = 1'b1;
        dREN      = 1'b1;
        iaddr     = 32'h0000_0500;
        daddr     = 32'h0000_0600;
        ram_ready = 1'b1;
        ram_load  = 32'hCAFE_F00D;
        for (int g = 0; g < 10; g++) begin
            if ((g % 5) == 4) begin
                push(1'b0, 1'b0, 32'h0000_0500, 32'd0, 32'hCAFE_F00D);
            end else begin
                push(1'b1, 1'b0, 32'h0000_0600, 32'd0, 32'hCAFE_F00D);
            end
        end
        repeat (19) tick;
        tick;
        iREN      = 1'b0;
        dREN      = 1'b0;
        ram_ready = 1'b0;
        @(negedge CLK);
        chk("t3_sb_drained", sb_q.size(), 32'd0);

        // Test 4: withdrawal during DGNT after one streak grant.
        tick;
        iREN  = 1'b1;
        iaddr = 32'h0000_0700;
        dREN  = 1'b1;
        daddr = 32'h0000_0800;
        push(1'b1, 1'b0, 32'h0000_0800, 32'd0, 32'h1111_0000);
        tick;
        ram_ready = 1'b1;
        ram_load  = 32'h1111_0000;
        tick;
        ram_ready = 1'b0;
        tick;
        @(negedge CLK);
        chk("t4_gnt_d_c1", {31'd0, gnt_d}, 32'd1);
        chk("t4_ren_c1", {31'd0, ram_ren}, 32'd1);
        chk("t4_addr_c1", ram_addr, 32'h0000_0800);
        tick;
        dREN = 1'b0;
        @(negedge CLK);
        chk("t4_dwait_c2", {31'd0, dwait}, 32'd0);
        tick;
        @(negedge CLK);
        chk("t4_idle_c3", {30'd0, gnt_i, gnt_d}, 32'd0);
        chk("t4_strobe_c3", {30'd0, ram_ren, ram_wen}, 32'd0);
        chk("t4_dwait_c3", {31'd0, dwait}, 32'd0);
        chk("t4_dstreak", {28'd0, dut.dstreak_r}, 32'd2);
        push(1'b0, 1'b0, 32'h0000_0700, 32'd0, 32'h2222_0000);
        tick;
        @(negedge CLK);
        chk("t4_gnt_i_c4", {31'd0, gnt_i}, 32'd1);
        tick;
        ram_ready = 1'b1;
        ram_load  = 32'h2222_0000;
        tick;
        ram_ready = 1'b0;
        iREN      = 1'b0;

        // Test 5: reset during an instruction grant.
        tick;
        iREN  = 1'b1;
        iaddr = 32'h0000_0900;
        tick;
        @(negedge CLK);
        chk("t5_gnt_i_c1", {31'd0, gnt_i}, 32'd1);
        RST = 1'b1;
        tick;
        RST = 1'b0;
        @(negedge CLK);
        chk("t5_gnt_i", {31'd0, gnt_i}, 32'd0);
        chk("t5_ren", {31'd0, ram_ren}, 32'd0);
        chk("t5_iwait", {31'd0, iwait}, 32'd1);
        chk("t5_dstreak", {28'd0, dut.dstreak_r}, 32'd0);
        push(1'b0, 1'b0, 32'h0000_0900, 32'd0, 32'h0BAD_F00D);
        tick;
        ram_ready = 1'b1;
        ram_load  = 32'h0BAD_F00D;
        tick;
        ram_ready = 1'b0;
        iREN      = 1'b0;

        // Test 6: dREN and dWEN together is a write.
        tick;
        dREN     = 1'b1;
        dWEN     = 1'b1;
        daddr    = 32'h0000_0040;
        dstore   = 32'h0000_0077;
        ram_load = 32'h0000_0000;
        push(1'b1, 1'b1, 32'h0000_0040, 32'h0000_0077, 32'h0000_0000);
        tick;
        @(negedge CLK);
        chk("t6_wen", {31'd0, ram_wen}, 32'd1);
        chk("t6_ren", {31'd0, ram_ren}, 32'd0);
        chk("t6_addr", ram_addr, 32'h0000_0040);
        tick;
        ram_ready = 1'b1;
        tick;
        ram_ready = 1'b0;
        dREN      = 1'b0;
        dWEN      = 1'b0;

        // Test 7: data reads with RAM latency k = 0..3.
        for (int k = 0; k < 4; k++) begin
            tick;
            dREN   = 1'b1;
            daddr  = $urandom;
            rnd_ld = $urandom;
            push(1'b1, 1'b0, daddr, 32'd0, rnd_ld);
            tick;
            for (int j = 0; j < k; j++) begin
                @(negedge CLK);
                chk("t7_dwait_hold", {31'd0, dwait}, 32'd1);
                tick;
            end
            ram_ready = 1'b1;
            ram_load  = rnd_ld;
            tick;
            ram_ready = 1'b0;
            dREN      = 1'b0;
        end

        tick;
        @(negedge CLK);
        chk("sb_empty_end", sb_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbitrates between the instruction cache and the data cache for one single-ported RAM.
- Sits below the caches and above the RAM model: one grant at a time, held until the RAM signals ready.
- Data requests win by default; a starvation limit guarantees the instruction side gets a slot.

Parameters:
ADDR_W, 32, address width in bits.
DATA_W, 32, data word width in bits.
MAX_DSTREAK, 4, max consecutive data grants while an instruction request is pending (range 1..15).

Ports:
CLK  input  1  system clock; everything updates on the rising edge.
RST  input  1  synchronous active-high reset.
iREN  input  1  instruction read request; held until iwait falls.
iaddr  input  ADDR_W  instruction address.
iload  output  DATA_W  instruction read data; valid when iwait=0 with iREN=1.
iwait  output  1  instruction stall.
dREN  input  1  data read request.
dWEN  input  1  data write request; wins if dREN is also high.
daddr  input  ADDR_W  data address.
dstore  input  DATA_W  data write value.
dload  output  DATA_W  data read value.
dwait  output  1  data stall.
ram_ren  output  1  RAM read strobe.
ram_wen  output  1  RAM write strobe.
ram_addr  output  ADDR_W  RAM address.
ram_store  output  DATA_W  RAM write data.
ram_load  input  DATA_W  RAM read data.
ram_ready  input  1  RAM access complete this cycle.
gnt_i  output  1  state==IGNT.
gnt_d  output  1  state==DGNT.

Behaviour:
- Reset: on a CLK edge with RST=1, state<=IDLE and dstreak<=0. Reset wins over any in-flight access; the access is dropped and no completion is reported.
- Output values at and after reset:
  - ram_ren, ram_wen, gnt_i, gnt_d = 0.
  - ram_addr, ram_store = 0.
  - iwait = iREN; dwait = dREN|dWEN.
- State machine has three registered states: IDLE, IGNT, DGNT.
- IDLE transitions, based on the current requests:
  - d_req=(dREN|dWEN) and iREN=0 -> DGNT.
  - iREN and not d_req -> IGNT.
  - both pending: IGNT if dstreak==MAX_DSTREAK, else DGNT.
  - neither pending -> stay in IDLE.
- dstreak update, on entry to a grant state:
  - entering DGNT with iREN=1: dstreak+1, saturating at MAX_DSTREAK.
  - entering DGNT with iREN=0: dstreak<=0.
  - entering IGNT: dstreak<=0.
- RAM outputs, combinational from the state and the granted requester's current inputs:
  - IGNT: ram_ren=1, ram_addr=iaddr.
  - DGNT with dWEN: ram_wen=1, ram_addr=daddr, ram_store=dstore.
  - DGNT with dREN only: ram_ren=1, ram_addr=daddr.
  - IDLE: all zero.
- Completion in a grant state with ram_ready=1:
  - the granted wait signal is 0 that same cycle.
  - iload/dload = ram_load.
  - next state is IDLE.
- Wait signals: iwait = iREN & ~(state==IGNT & ram_ready). dwait = d_req & ~(state==DGNT & ram_ready).
- Load outputs: iload and dload always follow ram_load. Callers qualify them with wait.
- Withdrawal: if the granted requester drops its request before ram_ready, the state goes to IDLE next cycle, with no completion and no dstreak change.
- Mandatory IDLE cycle: every completion passes through IDLE for one cycle. This keeps a request that is still high on its completion cycle from being regranted.
- Latency: a request seen in IDLE at cycle 0 has its RAM strobe at cycle 1. Completion comes at cycle 1+k for a RAM that needs k extra cycles (k≥0). Minimum service time is 2 cycles.
- ram_ready in IDLE is ignored.
- dREN and dWEN both high is treated as a write.

Test Plan:
1. Isolated read: RST pulse, then iREN=1, iaddr=0x100; ram_ready=1 at cycle 3 with ram_load=0xDEADBEEF.
   - Required: gnt_i=1 from cycle 1; iwait=1 at cycles 0–2, 0 at cycle 3 with iload=0xDEADBEEF; IDLE at cycle 4.
2. Simultaneous requests: iREN=1 and dWEN=1 (daddr=0x200, dstore=0x55) at IDLE, ram_ready=1 one cycle after each grant.
   - Required: DGNT first with ram_wen=1, ram_addr=0x200, ram_store=0x55; IGNT on the next arbitration.
3. Starvation limit: MAX_DSTREAK=4, iREN and dREN held high continuously, ram_ready always 1.
   - Required grant sequence: D,D,D,D,I,D,D,D,D,I; every grant separated by one IDLE cycle.
4. Withdrawal: DGNT with dREN=1, ram_ready=0, then dREN drops at cycle 2.
   - Required: IDLE at cycle 3; dwait=0; no ram strobe at cycle 3; dstreak unchanged.
5. Reset mid-access: RST=1 during IGNT with ram_ready=0.
   - Required: next edge gives state IDLE, ram_ren=0, gnt_i=0, iwait=iREN, dstreak=0.
6. Illegal dREN&dWEN: both high, daddr=0x40.
   - Required: ram_wen=1, ram_ren=0, ram_addr=0x40.
